// File: rtl/sar_search_4b_if.sv
// Comparator-side bundle for the 4-bit successive-approximation search.
// SAR_ITER_COUNT_EN adds the iters count of the last search.
interface sar_search_4b_if;
   logic       start;
   logic       greater;
   logic       lesser;
   logic       equal;
   logic [3:0] guess;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic       found;
   logic       err;
`ifdef SAR_ITER_COUNT_EN
   logic [2:0] iters;

   modport master (
      output start, greater, lesser, equal,
      input  guess, busy, done, result, found, err, iters
   );
   modport slave (
      input  start, greater, lesser, equal,
      output guess, busy, done, result, found, err, iters
   );
`else
   modport master (
      output start, greater, lesser, equal,
      input  guess, busy, done, result, found, err
   );
   modport slave (
      input  start, greater, lesser, equal,
      output guess, busy, done, result, found, err
   );
`endif
endinterface

// File: rtl/sar_search_4b.sv
// Binary search of a 4-bit target driven by an external comparator.
// SAR_ITER_COUNT_EN adds the iters output (COMPARE cycles of last search).
module sar_search_4b (
   input  logic          clk,
   input  logic          rst,
   sar_search_4b_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

   state_t     state, state_n;
   logic [3:0] lo, lo_n;
   logic [3:0] hi, hi_n;
   logic [3:0] guess, guess_n;
   logic [3:0] result, result_n;
   logic       found, found_n;
   logic       err, err_n;
   logic [4:0] lo_g;
   logic [3:0] gm1;
   logic       flags_ok;

   // lo_g is 5 bits so that a greater at guess 15 overflows to 16
   assign lo_g     = {1'b0, guess} + 5'd1;
   assign gm1      = guess - 4'd1;
   assign flags_ok = $onehot({bus.greater, bus.lesser, bus.equal});

`ifdef SAR_ITER_COUNT_EN
   logic [2:0] iters, iters_n;
   assign bus.iters = iters;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         lo     <= 4'd0;
         hi     <= 4'd15;
         guess  <= 4'd0;
         result <= 4'd0;
         found  <= 1'b0;
         err    <= 1'b0;
`ifdef SAR_ITER_COUNT_EN
         iters  <= 3'd0;
`endif
      end else begin
         state  <= state_n;
         lo     <= lo_n;
         hi     <= hi_n;
         guess  <= guess_n;
         result <= result_n;
         found  <= found_n;
         err    <= err_n;
`ifdef SAR_ITER_COUNT_EN
         iters  <= iters_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      lo_n     = lo;
      hi_n     = hi;
      guess_n  = guess;
      result_n = result;
      found_n  = found;
      err_n    = err;
`ifdef SAR_ITER_COUNT_EN
      iters_n  = iters;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n  = COMPARE;
               lo_n     = 4'd0;
               hi_n     = 4'd15;
               guess_n  = 4'd7;
               result_n = 4'd0;
               found_n  = 1'b0;
               err_n    = 1'b0;
`ifdef SAR_ITER_COUNT_EN
               iters_n  = 3'd0;
`endif
            end
         end
         COMPARE: begin
`ifdef SAR_ITER_COUNT_EN
            iters_n = iters + 3'd1;
`endif
            if (!flags_ok) begin
               state_n = DONE;
               err_n   = 1'b1;
               found_n = 1'b0;
            end else begin
               unique case (1'b1)
                  bus.equal: begin
                     state_n  = DONE;
                     result_n = guess;
                     found_n  = 1'b1;
                     err_n    = 1'b0;
                  end
                  bus.greater: begin
                     if (lo_g > {1'b0, hi}) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                        found_n = 1'b0;
                     end else begin
                        lo_n    = lo_g[3:0];
                        guess_n = 4'((lo_g + {1'b0, hi}) >> 1);
                     end
                  end
                  bus.lesser: begin
                     if (guess == 4'd0 || gm1 < lo) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                        found_n = 1'b0;
                     end else begin
                        hi_n    = gm1;
                        guess_n = 4'(({1'b0, lo} + {1'b0, gm1}) >> 1);
                     end
                  end
               endcase
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.guess  = guess;
   assign bus.result = result;
   assign bus.found  = found;
   assign bus.err    = err;
   assign bus.busy   = (state == COMPARE);
   assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_sar_search_4b.sv
// Directed bench for sar_search_4b with a model comparator and flag overrides.
// Define SAR_ITER_COUNT_EN on both RTL and bench to cover iters.
module tb_sar_search_4b;
   logic       clk;
   logic       rst;
   logic [3:0] target;
   logic       force_en;
   logic [2:0] force_val;
   int         checks;
   int         failures;

   sar_search_4b_if bus ();

   sar_search_4b dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model comparator; force_val is {greater, lesser, equal}
   always_comb begin
      if (force_en) begin
         {bus.greater, bus.lesser, bus.equal} = force_val;
      end else begin
         bus.greater = (target > bus.guess);
         bus.lesser  = (target < bus.guess);
         bus.equal   = (target == bus.guess);
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      #1;
      checks++;
      if ({bus.guess, bus.result, bus.busy, bus.done, bus.found, bus.err}
          !== 12'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
            {bus.guess, bus.result, bus.busy, bus.done, bus.found, bus.err});
      end
`ifdef SAR_ITER_COUNT_EN
      checks++;
      if (bus.iters !== 3'd0) begin
         failures++;
         $display("FAIL reset_iters got=%0d exp=0", bus.iters);
      end
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_search(input logic [3:0] tgt, input int n,
                              input logic [3:0] seq [5]);
      target = tgt;
      force_en = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (bus.guess !== seq[i] || bus.busy !== 1'b1 || bus.done !== 1'b0)
         begin
            failures++;
            $display("FAIL search%0d_step%0d got guess=%0d busy=%b done=%b exp guess=%0d busy=1 done=0",
               tgt, i, bus.guess, bus.busy, bus.done, seq[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== tgt ||
          bus.found !== 1'b1 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL search%0d_done got done=%b busy=%b result=%0d found=%b err=%b exp 1 0 %0d 1 0",
            tgt, bus.done, bus.busy, bus.result, bus.found, bus.err, tgt);
      end
`ifdef SAR_ITER_COUNT_EN
      checks++;
      if (bus.iters !== 3'(n)) begin
         failures++;
         $display("FAIL search%0d_iters got=%0d exp=%0d", tgt, bus.iters, n);
      end
`endif
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== tgt ||
          bus.found !== 1'b1 || bus.guess !== tgt) begin
         failures++;
         $display("FAIL search%0d_hold got done=%b busy=%b result=%0d found=%b guess=%0d exp 0 0 %0d 1 %0d",
            tgt, bus.done, bus.busy, bus.result, bus.found, bus.guess, tgt, tgt);
      end
   endtask

   task automatic test_bad_flags(input logic [2:0] fv);
      force_en = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      force_en = 1'b1;
      force_val = fv;
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.found !== 1'b0 ||
          bus.result !== 4'd0) begin
         failures++;
         $display("FAIL bad_flags_%b got done=%b err=%b found=%b result=%0d exp 1 1 0 0",
            fv, bus.done, bus.err, bus.found, bus.result);
      end
      force_en = 1'b0;
      @(negedge clk);
   endtask

   // always-greater runs off the top; always-lesser runs off the bottom
   task automatic test_range_exhaust(input logic [2:0] fv, input int n,
                                     input logic [3:0] seq [5]);
      force_en = 1'b1;
      force_val = fv;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (bus.guess !== seq[i] || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL exhaust_%b_step%0d got guess=%0d busy=%b exp %0d 1",
               fv, i, bus.guess, bus.busy, seq[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.found !== 1'b0 ||
          bus.guess !== seq[n-1]) begin
         failures++;
         $display("FAIL exhaust_%b_done got done=%b err=%b found=%b guess=%0d exp 1 1 0 %0d",
            fv, bus.done, bus.err, bus.found, bus.guess, seq[n-1]);
      end
`ifdef SAR_ITER_COUNT_EN
      checks++;
      if (bus.iters !== 3'(n)) begin
         failures++;
         $display("FAIL exhaust_%b_iters got=%0d exp=%0d", fv, bus.iters, n);
      end
`endif
      force_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_start_ignored_and_abort();
      logic saw_done;
      target = 4'd15;
      force_en = 1'b0;
      saw_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.guess !== 4'd13 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL start_ignored got guess=%0d busy=%b exp 13 1",
            bus.guess, bus.busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.guess, bus.result, bus.busy, bus.done, bus.found, bus.err}
          !== 12'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%h exp=0",
            {bus.guess, bus.result, bus.busy, bus.done, bus.found, bus.err});
      end
      repeat (2) begin
         @(negedge clk);
         saw_done |= bus.done;
      end
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1 saw_done |= bus.done;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done got=%b exp=0", saw_done);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      target = 4'd0;
      force_en = 1'b0;
      force_val = 3'b000;
      bus.start = 1'b0;
      test_reset();
      test_search(4'd15, 5, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15});
      test_search(4'd0, 4, '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0});
      test_search(4'd7, 1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0});
      test_search(4'd10, 4, '{4'd7, 4'd11, 4'd9, 4'd10, 4'd0});
      test_bad_flags(3'b000);
      test_bad_flags(3'b110);
      test_bad_flags(3'b111);
      test_range_exhaust(3'b100, 5, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15});
      test_range_exhaust(3'b010, 4, '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0});
      test_start_ignored_and_abort();
      test_search(4'd15, 5, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst && bus.busy === 1'b1 && bus.done === 1'b1) begin
         failures++;
         $display("FAIL busy_done_overlap got busy=1 done=1 exp not both");
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sar_search_4b.md
SAR_SEARCH_4B -- requirements
Module: sar_search_4b

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  search request; sampled in IDLE only
- greater  in  1  external 4-bit comparator flag: target > guess
- lesser  in  1  comparator flag: target < guess
- equal  in  1  comparator flag: target == guess
- guess  out  4  operand driven to the comparator
- busy  out  1  high while in COMPARE
- done  out  1  one-cycle completion pulse
- result  out  4  found value; valid from done onward
- found  out  1  search ended on equal
- err  out  1  search aborted on invalid flags or empty range

Function
REQ-003 The FSM SHALL have states IDLE, COMPARE and DONE, encoded internally.
REQ-004 In IDLE with start=1, the next state SHALL be COMPARE with lo=0, hi=15, guess=7 and result/found/err cleared; busy rises the same edge.
REQ-005 start SHALL be ignored in COMPARE and DONE.
REQ-006 In COMPARE, the flags SHALL be sampled every cycle against the guess currently on the port, which is registered and stable for the whole cycle.
REQ-007 Flags SHALL be valid only if exactly one of greater/lesser/equal is 1.
- Any other pattern: go to DONE with err=1 and found=0.
REQ-008 On equal, the block SHALL go to DONE with result=guess, found=1 and err=0.
REQ-009 On greater, the block SHALL set lo=guess+1, computed 5 bits wide so that guess=15 gives 16.
- If lo>hi: go to DONE with err=1 and found=0.
- Otherwise: guess=(lo+hi)>>1, computed 5 bits wide, and stay in COMPARE.
REQ-010 On lesser, the block SHALL handle the lower bound as follows.
- If guess=0 or guess-1<lo: go to DONE with err=1 and found=0.
- Otherwise: hi=guess-1, guess=(lo+hi)>>1, and stay in COMPARE.
REQ-011 A consistent comparator SHALL produce found=1 within at most 5 COMPARE cycles.
- Worst case: target 15, guesses 7,11,13,14,15.
REQ-012 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-013 result, found, err and guess SHALL hold their values in IDLE until the next accepted start.
REQ-014 busy and done SHALL never be high in the same cycle.

Reset
REQ-015 On rst=1, the block SHALL go to IDLE at once with guess=0, result=0, busy=0, done=0, found=0, err=0, lo=0 and hi=15.
REQ-016 A reset in the middle of COMPARE SHALL abort the search without a done pulse; start is accepted on the first edge after rst falls.

Configuration
REQ-017 With SAR_ITER_COUNT_EN defined, the block SHALL add the output iters (3 bits), holding the number of COMPARE cycles of the last search, including the final one.
- iters resets to 0, clears on an accepted start, and holds after DONE.
REQ-018 Without SAR_ITER_COUNT_EN, the iters port and its counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-019 Target 15 with a model comparator, pulse start -> guess sequence 7,11,13,14,15; done one cycle after the 15 compare; result=15, found=1, err=0; iters=5 when the macro is enabled.
REQ-020 Target 0 -> guess sequence 7,3,1,0; result=0, found=1; iters=4.
REQ-021 Target 7 -> a single COMPARE cycle; done on the 2nd edge after start; result=7.
REQ-022 Force flags to 000 on the first compare, then separately to 110 -> DONE next edge with err=1, found=0, result=0.
REQ-023 Comparator reporting greater at guess 15 (inconsistent) -> err=1 via the lo>hi rule; no wrap to guess 0.
REQ-024 Pulse start at the 2nd COMPARE cycle -> no effect. Assert rst at the 3rd COMPARE cycle -> all outputs 0 immediately, no done pulse; a new start then runs a full search correctly.
